// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin picker: first set request at or above ptr, with wrap
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int c;

  // Walk offsets from far to near so the nearest set bit overwrites the rest.
  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        any = 1'b1;
        idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of one synchronous memory port
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      s_mem_req,
  input  logic [NUM_REQ-1:0]      s_mem_we,
  input  logic [NUM_REQ*XLEN-1:0] s_mem_addr,
  input  logic [NUM_REQ*XLEN-1:0] s_mem_wdata,
  output logic [XLEN-1:0]         s_mem_rdata,
  output logic [NUM_REQ-1:0]      s_mem_ready,
  output logic [NUM_REQ-1:0]      s_mem_err,
  output logic                    m_mem_req,
  output logic                    m_mem_we,
  output logic [XLEN-1:0]         m_mem_addr,
  output logic [XLEN-1:0]         m_mem_wdata,
  input  logic [XLEN-1:0]         m_mem_rdata,
  input  logic                    m_mem_ready,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  mem_cmd_t         cmd_q, cmd_d, cmd_pick;
  logic             mreq_q, mreq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_any;
  logic [ID_W-1:0]  pick_idx;
  logic             timeout;

  rr_pick #(.N(NUM_REQ), .IDX_W(ID_W)) u_pick (
    .req (s_mem_req),
    .ptr (rr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    cmd_pick.we    = s_mem_we[pick_idx];
    cmd_pick.addr  = s_mem_addr[int'(pick_idx)*XLEN +: XLEN];
    cmd_pick.wdata = s_mem_wdata[int'(pick_idx)*XLEN +: XLEN];
  end

  assign timeout = (state_q == ARB_WAIT) && !m_mem_ready &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    cmd_d       = cmd_q;
    mreq_d      = 1'b0;
    cnt_d       = cnt_q;
    s_mem_ready = '0;
    s_mem_err   = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cmd_d   = cmd_pick;
          mreq_d  = 1'b1;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = '0;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Completion and timeout both hand the pointer to the next requester.
        if (m_mem_ready || timeout) begin
          s_mem_ready[grant_q] = m_mem_ready;
          s_mem_err[grant_q]   = timeout;
          rr_d    = ID_W'(wrap_inc(int'(grant_q), NUM_REQ));
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      cmd_q   <= '0;
      mreq_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cmd_q   <= cmd_d;
      mreq_q  <= mreq_d;
      cnt_q   <= cnt_d;
    end
  end

  assign s_mem_rdata = m_mem_rdata;
  assign m_mem_req   = mreq_q;
  assign m_mem_we    = cmd_q.we;
  assign m_mem_addr  = cmd_q.addr;
  assign m_mem_wdata = cmd_q.wdata;
  assign busy        = (state_q != ARB_IDLE);
  assign grant_id    = grant_q;

  a_resp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(s_mem_ready | s_mem_err));
  a_single_issue: assert property (@(posedge clk) disable iff (!rst_n)
    m_mem_req |=> !m_mem_req);
  a_grant_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != ARB_IDLE) |-> s_mem_req[grant_q]);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_mem_req, s_mem_we, s_mem_ready, s_mem_err;
  logic [63:0] s_mem_addr, s_mem_wdata;
  logic [31:0] s_mem_rdata, m_mem_addr, m_mem_wdata, m_mem_rdata;
  logic        m_mem_req, m_mem_we, m_mem_ready, busy;
  logic [0:0]  grant_id;

  logic        bram_rdy, slave_dead, stray_ready;
  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_mem_req(s_mem_req), .s_mem_we(s_mem_we), .s_mem_addr(s_mem_addr),
    .s_mem_wdata(s_mem_wdata), .s_mem_rdata(s_mem_rdata), .s_mem_ready(s_mem_ready),
    .s_mem_err(s_mem_err), .m_mem_req(m_mem_req), .m_mem_we(m_mem_we),
    .m_mem_addr(m_mem_addr), .m_mem_wdata(m_mem_wdata), .m_mem_rdata(m_mem_rdata),
    .m_mem_ready(m_mem_ready), .busy(busy), .grant_id(grant_id)
  );

  // BRAM model: ready one cycle after req is sampled; can be made unresponsive.
  always @(posedge clk) begin
    bram_rdy <= m_mem_req && !slave_dead;
    if (m_mem_req) begin
      m_mem_rdata <= mem[m_mem_addr[9:2]];
      if (m_mem_we) mem[m_mem_addr[9:2]] <= m_mem_wdata;
    end
  end
  assign m_mem_ready = bram_rdy | stray_ready;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_mem_req = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called 1 time unit after a rising edge with the arbiter in IDLE; cycle 0 is that cycle.
  task automatic run_txn(input int id, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [1:0] rdy,
                         output logic [1:0] err, output logic [31:0] rdata,
                         output int lat, output int mreq_cyc, output int mreq_cnt,
                         output logic [31:0] maddr);
    rdy = '0; err = '0; rdata = '0; lat = -1; mreq_cyc = -1; mreq_cnt = 0; maddr = '0;
    s_mem_we[id] = we;
    s_mem_addr[id*32 +: 32] = addr;
    s_mem_wdata[id*32 +: 32] = wdata;
    s_mem_req[id] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_mem_req) begin
        mreq_cnt++;
        mreq_cyc = c;
        maddr = m_mem_addr;
      end
      if (s_mem_ready != 0 || s_mem_err != 0) begin
        rdy = s_mem_ready; err = s_mem_err; rdata = s_mem_rdata; lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_mem_req[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rdy, err;
    logic [31:0] rdata, maddr;
    int          lat, mcyc, mcnt, n;
    logic [1:0]  who [4];
    int          gid [4];
    int          cyc [4];

    vecs[0] = '{1, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h0};
    vecs[2] = '{0, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D};
    vecs[3] = '{1, 1'b1, 32'h84, 32'h12345678, 32'h0};
    vecs[4] = '{1, 1'b0, 32'h84, 32'h0,        32'h12345678};
    vecs[5] = '{0, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF};

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[16] = 32'hDEADBEEF;
    slave_dead = 1'b0; stray_ready = 1'b0;
    s_mem_req = '0; s_mem_we = '0; s_mem_addr = '0; s_mem_wdata = '0;
    rst_n = 1'b0;

    #3;
    chk("reset busy", busy, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset m_mem_req", m_mem_req, 0);
    chk("reset m_mem_we", m_mem_we, 0);
    chk("reset m_mem_addr", m_mem_addr, 0);
    chk("reset m_mem_wdata", m_mem_wdata, 0);
    chk("reset s_mem_ready", s_mem_ready, 0);
    chk("reset s_mem_err", s_mem_err, 0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wdata,
              rdy, err, rdata, lat, mcyc, mcnt, maddr);
      chk($sformatf("vec%0d ready", i), rdy, 64'(2'b01 << vecs[i].id));
      chk($sformatf("vec%0d err", i), err, 0);
      chk($sformatf("vec%0d latency", i), lat, 2);
      chk($sformatf("vec%0d m_mem_req cycle", i), mcyc, 1);
      chk($sformatf("vec%0d m_mem_req count", i), mcnt, 1);
      chk($sformatf("vec%0d m_mem_addr", i), maddr, vecs[i].addr);
      if (!vecs[i].we) chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
    end

    // Fairness: both requesters held continuously from a fresh reset.
    do_reset();
    s_mem_we = '0;
    s_mem_addr = {32'h40, 32'h40};
    s_mem_req = 2'b11;
    n = 0;
    for (int i = 0; i < 4; i++) begin who[i] = '0; gid[i] = -1; cyc[i] = -1; end
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (s_mem_ready != 0) begin
        who[n] = s_mem_ready; gid[n] = int'(grant_id); cyc[n] = c; n++;
      end
      @(posedge clk); #1;
    end
    s_mem_req = '0;
    chk("fair pulses", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fair%0d ready", i), who[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("fair%0d grant_id", i), gid[i], i % 2);
      chk($sformatf("fair%0d cycle", i), cyc[i], 2 + 3 * i);
    end
    @(posedge clk); #1;

    // Timeout on requester 1 with an unresponsive slave.
    slave_dead = 1'b1;
    run_txn(1, 1'b0, 32'h40, 32'h0, rdy, err, rdata, lat, mcyc, mcnt, maddr);
    chk("timeout err", err, 2'b10);
    chk("timeout ready", rdy, 0);
    chk("timeout cycle", lat, 9);
    chk("timeout m_mem_req count", mcnt, 1);

    stray_ready = 1'b1;
    @(negedge clk);
    chk("stray ready not forwarded", s_mem_ready, 0);
    chk("stray busy", busy, 0);
    @(posedge clk); #1;
    stray_ready = 1'b0;
    slave_dead = 1'b0;

    s_mem_req = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-timeout grant_id", grant_id, 0);
    chk("post-timeout m_mem_req", m_mem_req, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-timeout ready", s_mem_ready, 2'b01);
    @(posedge clk); #1;
    s_mem_req = '0;
    @(posedge clk); #1;

    // Asynchronous reset while waiting on the slave.
    slave_dead = 1'b1;
    s_mem_we[0] = 1'b0;
    s_mem_addr[31:0] = 32'h40;
    s_mem_req[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-wait busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset m_mem_req", m_mem_req, 0);
    chk("async reset m_mem_addr", m_mem_addr, 0);
    chk("async reset grant_id", grant_id, 0);
    chk("async reset ready/err", {s_mem_ready, s_mem_err}, 0);
    s_mem_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    slave_dead = 1'b0;
    @(posedge clk); #1;
    run_txn(0, 1'b0, 32'h40, 32'h0, rdy, err, rdata, lat, mcyc, mcnt, maddr);
    chk("after reset ready", rdy, 2'b01);
    chk("after reset latency", lat, 2);
    chk("after reset rdata", rdata, 32'hDEADBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
